// File: rtl/mux16_sel.sv
// mux16_sel: 16:1 WIDTH-bit multiplexer with a registered copy of the result.
// Typical use is cache byte selection, where sel_i is the address offset [3:0]
// and in0_i..in15_i are the 16 bytes of a 128-bit block.
//
// Ports:
//   clk              clock, registers update on the rising edge
//   rst              asynchronous active-high reset, clears the registers
//   sel_i[3:0]       select, value N picks inN_i
//   in0_i..in15_i    data inputs, WIDTH bits each
//   en_i             load enable for the registered outputs
//   out_o            combinational selected data (no clk/rst/en_i dependency)
//   out_q_o          registered selected data, one cycle behind out_o
//   sel_q_o[3:0]     select value captured together with out_q_o
//   par_q_o          (MUX16_PARITY_EN only) XOR reduction of the value loaded
//                    into out_q_o, registered alongside it
//
// Build option: define MUX16_PARITY_EN to add par_q_o and its parity register.
module mux16_sel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sel_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [WIDTH-1:0] in3_i,
  input  logic [WIDTH-1:0] in4_i,
  input  logic [WIDTH-1:0] in5_i,
  input  logic [WIDTH-1:0] in6_i,
  input  logic [WIDTH-1:0] in7_i,
  input  logic [WIDTH-1:0] in8_i,
  input  logic [WIDTH-1:0] in9_i,
  input  logic [WIDTH-1:0] in10_i,
  input  logic [WIDTH-1:0] in11_i,
  input  logic [WIDTH-1:0] in12_i,
  input  logic [WIDTH-1:0] in13_i,
  input  logic [WIDTH-1:0] in14_i,
  input  logic [WIDTH-1:0] in15_i,
  input  logic             en_i,
`ifdef MUX16_PARITY_EN
  output logic             par_q_o,
`endif
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] out_q_o,
  output logic [3:0]       sel_q_o
);

  // All 16 select codes are listed explicitly; the leading assignment only
  // keeps the block latch-free and is always overridden by one of the arms.
  always_comb begin
    out_o = in0_i;
    case (sel_i)
      4'd0:  out_o = in0_i;
      4'd1:  out_o = in1_i;
      4'd2:  out_o = in2_i;
      4'd3:  out_o = in3_i;
      4'd4:  out_o = in4_i;
      4'd5:  out_o = in5_i;
      4'd6:  out_o = in6_i;
      4'd7:  out_o = in7_i;
      4'd8:  out_o = in8_i;
      4'd9:  out_o = in9_i;
      4'd10: out_o = in10_i;
      4'd11: out_o = in11_i;
      4'd12: out_o = in12_i;
      4'd13: out_o = in13_i;
      4'd14: out_o = in14_i;
      4'd15: out_o = in15_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q_o <= '0;
      sel_q_o <= '0;
    end else if (en_i) begin
      out_q_o <= out_o;
      sel_q_o <= sel_i;
    end
  end

`ifdef MUX16_PARITY_EN
  // Parity is taken from the same out_o value being loaded, so it always
  // describes the current contents of out_q_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q_o <= 1'b0;
    end else if (en_i) begin
      par_q_o <= ^out_o;
    end
  end
`endif

endmodule

// File: tb/tb_mux16_sel.sv
module tb_mux16_sel;

  logic        clk;
  logic        rst;
  logic [3:0]  sel;
  logic [7:0]  in_v [16];
  logic        en;
  logic [7:0]  out_c;
  logic [7:0]  out_q;
  logic [3:0]  sel_q;
`ifdef MUX16_PARITY_EN
  logic        par_q;
`endif

  int checks = 0;
  int errors = 0;

  mux16_sel #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel_i   (sel),
    .in0_i   (in_v[0]),
    .in1_i   (in_v[1]),
    .in2_i   (in_v[2]),
    .in3_i   (in_v[3]),
    .in4_i   (in_v[4]),
    .in5_i   (in_v[5]),
    .in6_i   (in_v[6]),
    .in7_i   (in_v[7]),
    .in8_i   (in_v[8]),
    .in9_i   (in_v[9]),
    .in10_i  (in_v[10]),
    .in11_i  (in_v[11]),
    .in12_i  (in_v[12]),
    .in13_i  (in_v[13]),
    .in14_i  (in_v[14]),
    .in15_i  (in_v[15]),
    .en_i    (en),
`ifdef MUX16_PARITY_EN
    .par_q_o (par_q),
`endif
    .out_o   (out_c),
    .out_q_o (out_q),
    .sel_q_o (sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] base;  // inN = base + N
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [7:0] base);
    for (int n = 0; n < 16; n++) in_v[n] = base + 8'(n);
  endtask

  initial begin
    logic [127:0] blk;

    // sweep with base 8'h10, then other bases including wrap-around
    for (int i = 0; i < 16; i++)
      vecs[i] = '{sel: 4'(i), base: 8'h10, exp: 8'h10 + 8'(i)};
    vecs[16] = '{sel: 4'd15, base: 8'hF0, exp: 8'hFF};
    vecs[17] = '{sel: 4'd9,  base: 8'hF8, exp: 8'h01};
    vecs[18] = '{sel: 4'd0,  base: 8'h5A, exp: 8'h5A};
    vecs[19] = '{sel: 4'd7,  base: 8'hC3, exp: 8'hCA};

    rst = 1'b1;
    en  = 1'b0;
    sel = 4'd0;
    fill(8'h00);
    #2;
    check("reset_out_q", 32'(out_q), 32'h0);
    check("reset_sel_q", 32'(sel_q), 32'h0);

    // combinational table, en low so nothing is captured
    for (int i = 0; i < 20; i++) begin
      fill(vecs[i].base);
      sel = vecs[i].sel;
      #1;
      check($sformatf("sweep_%0d", i), 32'(out_c), 32'(vecs[i].exp));
    end

    // rst high with en high across an edge: stays cleared
    sel = 4'd9;
    in_v[9] = 8'h77;
    en = 1'b1;
    @(posedge clk); #1;
    check("rst_edge_out_q", 32'(out_q), 32'h0);
    check("rst_edge_sel_q", 32'(sel_q), 32'h0);

    // release reset, first capture on the next edge
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("cap_out_q", 32'(out_q), 32'h77);
    check("cap_sel_q", 32'(sel_q), 32'd9);

    // hold with en low
    @(negedge clk);
    en = 1'b0;
    sel = 4'd2;
    in_v[2] = 8'h11;
    #1;
    check("hold_comb", 32'(out_c), 32'h11);
    @(posedge clk); #1;
    check("hold_out_q", 32'(out_q), 32'h77);
    check("hold_sel_q", 32'(sel_q), 32'd9);

    // async reset between edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_q", 32'(out_q), 32'h0);
    check("async_sel_q", 32'(sel_q), 32'h0);
    en = 1'b1;
    @(posedge clk); #1;
    check("rst_en_out_q", 32'(out_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // isolation: only in5 matters when sel=5
    sel = 4'd5;
    in_v[5] = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 16; n++)
        if (n != 5) in_v[n] = 8'($urandom);
      #1;
      check($sformatf("iso_%0d", k), 32'(out_c), 32'hA5);
    end
    in_v[5] = 8'h3C;
    #1;
    check("iso_change", 32'(out_c), 32'h3C);
    @(posedge clk); #1;
    check("iso_out_q", 32'(out_q), 32'h3C);
    check("iso_sel_q", 32'(sel_q), 32'd5);

    // cache byte select
    blk = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    for (int n = 0; n < 16; n++) in_v[n] = blk[n*8 +: 8];
    sel = 4'hB;
    #1;
    check("cache_b", 32'(out_c), 32'h0B);
    sel = 4'hF;
    #1;
    check("cache_f", 32'(out_c), 32'h0F);

    // back-to-back capture with changing select
    @(negedge clk);
    sel = 4'h3;
    @(posedge clk); #1;
    check("b2b_out_q", 32'(out_q), 32'h03);
    check("b2b_sel_q", 32'(sel_q), 32'h3);

`ifdef MUX16_PARITY_EN
    @(negedge clk);
    in_v[3] = 8'h07;
    sel = 4'd3;
    en = 1'b1;
    @(posedge clk); #1;
    check("par_07", 32'(par_q), 32'h1);
    @(negedge clk);
    in_v[3] = 8'h03;
    @(posedge clk); #1;
    check("par_03", 32'(par_q), 32'h0);
    @(negedge clk);
    in_v[3] = 8'h01;
    @(posedge clk); #1;
    check("par_01", 32'(par_q), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("par_rst", 32'(par_q), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
